// File: rtl/stack_pkg.sv
// stack_pkg: shared types and helpers for the stack_ctrl LIFO.
// Rev 1.0 - initial release.
`default_nettype none

package stack_pkg;

   typedef enum logic [2:0] {
      OP_IDLE    = 3'd0,
      OP_PUSH    = 3'd1,
      OP_POP     = 3'd2,
      OP_REPLACE = 3'd3,
      OP_PASS    = 3'd4,
      OP_CLEAR   = 3'd5
   } op_t;

   function automatic int clog2_cnt(input int depth);
      return $clog2(depth + 1);
   endfunction

   // OP_PUSH/OP_POP are still raised when full/empty; the controller turns
   // those into the sticky overflow/underflow cases.
   function automatic op_t decode_op(input logic clear, input logic push,
                                     input logic pop, input logic empty);
      op_t op;
      op = OP_IDLE;
      if (clear)
         op = OP_CLEAR;
      else if (push && !pop)
         op = OP_PUSH;
      else if (pop && !push)
         op = OP_POP;
      else if (push && pop)
         op = empty ? OP_PASS : OP_REPLACE;
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register array, one sync write port, one async read port.
// Rev 1.0 - initial release.
`default_nettype none

module stack_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Out-of-range addresses only occur for non-power-of-two depths.
   assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

`default_nettype wire

// File: rtl/stack_ctrl.sv
// stack_ctrl: parametrised LIFO with occupancy, peek, registered pop, replace-top and sticky errors.
// Rev 1.0 - initial release.
`default_nettype none

module stack_ctrl
   import stack_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int ALMOST_FULL = DEPTH - 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           clear,
   input  logic [WIDTH-1:0]               data_in,
   output logic [WIDTH-1:0]               data_out,
   output logic                           out_valid,
   output logic [WIDTH-1:0]               top,
   output logic [clog2_cnt(DEPTH)-1:0]    count,
   output logic                           empty,
   output logic                           full,
   output logic                           almost_full,
   output logic                           overflow,
   output logic                           underflow
);

   localparam int CW = clog2_cnt(DEPTH);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);

   op_t              op;
   logic             mem_we;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;

   assign empty       = (count == '0);
   assign full        = (count == DEPTH_C);
   assign almost_full = (count >= AF_C);

   assign op      = decode_op(clear, push, pop, empty);
   assign rd_addr = AW'(count - CW'(1));
   assign wr_addr = (op == OP_REPLACE) ? rd_addr : AW'(count);

   // Gating with rst keeps an edge seen during reset from touching the array.
   assign mem_we = rst && ((op == OP_REPLACE) || ((op == OP_PUSH) && !full));

   assign top = empty ? '0 : rd_data;

   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_addr),
      .wdata (data_in),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (op)
            OP_CLEAR: begin
               count     <= '0;
               overflow  <= 1'b0;
               underflow <= 1'b0;
            end
            OP_PUSH: begin
               if (full)
                  overflow <= 1'b1;
               else
                  count <= count + CW'(1);
            end
            OP_POP: begin
               if (empty) begin
                  underflow <= 1'b1;
               end else begin
                  data_out  <= rd_data;
                  count     <= count - CW'(1);
                  out_valid <= 1'b1;
               end
            end
            OP_REPLACE: begin
               data_out  <= rd_data;
               out_valid <= 1'b1;
            end
            OP_PASS: begin
               data_out  <= data_in;
               out_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Parametrised successor to the basic LIFO stack. Adds occupancy count, almost-full flag, combinational peek and a registered pop output with a valid strobe.
- Also adds simultaneous push+pop (replace-top), a synchronous flush, and sticky overflow/underflow error flags.
- Used as the operand/return-address stack in datapath blocks. Single clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of entries (>=2).
- ALMOST_FULL, DEPTH-1, count threshold at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  push request.
- pop  in  1  pop request.
- clear  in  1  synchronous flush; dominates push/pop.
- data_in  in  WIDTH  word to push.
- data_out  out  WIDTH  registered popped word; holds its value between pops.
- out_valid  out  1  one-cycle strobe: data_out was updated by the last edge.
- top  out  WIDTH  combinational peek at the top entry; 0 when empty.
- count  out  CW=$clog2(DEPTH+1)  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_full  out  1  count>=ALMOST_FULL.
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop rejected while empty.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - count=0, data_out=0, out_valid=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_full=0 (given ALMOST_FULL>=1).
  - The memory array is not reset.
  - Reset asserted mid-operation aborts any in-flight push/pop immediately.
- Status outputs empty/full/almost_full/top are combinational from count and memory. They reflect the state after the last edge.
- Each edge evaluates in priority order:
  1. clear: count<=0; overflow<=0; underflow<=0; out_valid<=0; data_out holds. push/pop are ignored that cycle.
  2. push & !pop & !full: mem[count]<=data_in; count<=count+1; out_valid<=0.
  3. push & !pop & full: write dropped; count holds; overflow<=1; out_valid<=0.
  4. pop & !push & !empty: data_out<=mem[count-1]; count<=count-1; out_valid<=1.
  5. pop & !push & empty: data_out holds; underflow<=1; out_valid<=0.
  6. push & pop & !empty (replace-top): data_out<=mem[count-1]; mem[count-1]<=data_in; count holds; out_valid<=1. Legal when full; no overflow.
  7. push & pop & empty (pass-through): data_out<=data_in; count stays 0; out_valid<=1; no underflow.
  8. idle: out_valid<=0; everything else holds.
- Pop latency is 1 cycle: the value is visible on data_out after the edge that samples pop.
- top updates the same edge as the count change.
- overflow and underflow clear only on reset or clear.
- count never wraps: it saturates at 0 and DEPTH by rules 3 and 5.

Decomposition:
- Package stack_pkg holds:
  - function clog2_cnt(depth), which returns $clog2(depth+1) for counter width.
  - localparam enum for the decoded operation: OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE, OP_PASS, OP_CLEAR.
- Sub-module stack_mem: DEPTH×WIDTH register array, one synchronous write port, one asynchronous read port (address = count-1). No reset.
- stack_ctrl holds the op decode, the counter, the flags and the output register.

Test Plan:
Use WIDTH=8, DEPTH=4, ALMOST_FULL=3.
1. Reset, then push AA, BB, CC, DD.
   - count 1,2,3,4; almost_full at count=3; full=1 after DD; top=DD.
   - Then 4 pops: data_out DD, CC, BB, AA, each with a 1-cycle out_valid; empty=1 at the end.
2. Full stack plus push 55 → count stays 4, overflow=1 and sticks, top=DD. Then clear → count=0, empty=1, overflow=0.
3. Empty stack plus pop → underflow=1, out_valid=0, data_out unchanged. Then push+pop with data_in=77 → data_out=77, out_valid=1, count=0, empty=1.
4. Push 11, 22, then push+pop with data_in=33 → data_out=22, count=2, top=33. Then pop → data_out=33; pop → data_out=11.
5. Full stack plus simultaneous push+pop with 99 → data_out=DD, count=4, top=99, overflow=0.
6. Push 3 words, drive rst=0 asynchronously between edges → count=0, data_out=0, out_valid=0, flags 0 immediately. Release, then push 42 → top=42, count=1.
